reservation_station: RTL and testbench
======================================

Name: reservation_station

Overview:
- Sits directly downstream of the decode/decompose stage.
- Buffers up to DEPTH decomposed instructions (116-bit packet) whose source operands may still be pending.
- Captures pending operands from the common data bus (CDB), then issues the oldest fully ready entry to the execute stage through a registered valid/ready output.
- Entry storage is a compacting shift queue, so entry 0 is always the oldest.

Parameters:
- DEPTH, 4, number of entries (2..8).
- TAG_W, 5, width of the producer tag carried in vt[4:0] when the operand is not valid.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- flush  input  1  synchronous clear of all entries and the output register (branch mispredict).
- in_valid  input  1  decode presents a packet.
- in_ready  output  1  station can accept a packet this cycle.
- in_inst  input  116  packet layout: rd[4:0], s1_valid[5], rs1_vt[37:6], s2_valid[38], rs2_vt[70:39], ctrl[83:71], memdata[115:84]. When sX_valid=0, vt[TAG_W-1:0] is the producer tag.
- cdb_valid  input  1  result broadcast valid.
- cdb_tag  input  TAG_W  tag of the broadcast result.
- cdb_data  input  32  broadcast result value.
- out_valid  output  1  issued packet valid.
- out_ready  input  1  execute stage accepts the packet.
- out_inst  output  116  issued packet; s1_valid=s2_valid=1 and vt fields hold values.
- count  output  $clog2(DEPTH)+1  number of occupied entries, excluding the output register.

Behaviour:
- Reset (rst_n=0, asynchronous): all entries invalid, count=0, out_valid=0, out_inst=0, in_ready=1.
- Accept:
  - handshake = in_valid & in_ready.
  - in_ready = (count < DEPTH) & ~flush. A slot freed by a same-cycle issue is not reused that cycle.
- Wake-up on capture: each incoming operand with valid=0 is compared against the CDB in the cycle of acceptance. If cdb_valid and the tag matches, the entry is stored with vt=cdb_data and valid=1. This CDB bypass is mandatory.
- Wake-up while resident: every cycle, for each occupied entry and each operand with valid=0, if cdb_valid and vt[TAG_W-1:0]==cdb_tag, then vt<=cdb_data and valid<=1.
  - s1 and s2 of the same entry may wake in the same cycle.
  - memdata is also replaced by cdb_data when s2 wakes.
- Ready: an entry is ready when s1_valid & s2_valid, evaluated on registered state. An entry woken this cycle is ready next cycle.
- Select: pick the lowest-index (oldest) ready entry. Selection happens only when out_valid=0 or (out_valid & out_ready).
- Issue:
  - The selected entry moves to the output register: out_valid<=1 and out_inst<=entry, one cycle after it is ready.
  - Entries above the selected index shift down by one, and count decrements.
- Output hold: if out_valid & ~out_ready, out_inst and out_valid are held stable and no selection occurs.
- Output drain: if no entry is ready and out_ready is high, out_valid<=0.
- Simultaneous accept and issue: the shift happens first, then the new packet is written at index count-1 (post-shift tail). count is unchanged.
- Full station (count=DEPTH): in_ready=0. An issue in that cycle lowers count, so in_ready=1 on the next cycle.
- Empty station with a ready packet arriving: the packet is written to an entry first. Minimum latency from in to out_valid is 2 cycles; there is no in-to-out bypass.
- Flush: on the next edge all entries are invalid, count=0 and out_valid=0. Any in_valid in the flush cycle is dropped. Flush has priority over accept, issue and wake-up.
- Tag zero: tags are compared only for operands with valid=0. Valid operands are never overwritten by the CDB.
- count never exceeds DEPTH and never underflows. An assertion in the bench checks this.

Test Plan:
- Reset/accept/issue: deassert rst_n mid-run with 2 entries and out_valid=1 -> count=0 and out_valid=0 immediately. Then accept a packet with both valid, rs1=5, rs2=7 -> out_valid=1 two cycles after acceptance, out_inst rs1_vt=5, rs2_vt=7.
- CDB wake-up: accept a packet with s1_valid=0, tag 3; after 3 idle cycles drive cdb_valid=1, cdb_tag=3, cdb_data=0xDEADBEEF -> issued the cycle after next with rs1_vt=0xDEADBEEF and s1_valid=1.
- Capture bypass: in_valid with s2 tag 9 while cdb_valid=1, cdb_tag=9, cdb_data=0x11 in the same cycle -> packet issues with rs2_vt=0x11 and memdata=0x11. It must not wait for a later broadcast.
- Oldest-first/out-of-order: fill 4 entries where entry0 waits on tag 2 and entries 1-3 are ready -> issue order 1,2,3. Broadcast tag 2 -> entry0 issues last. in_ready=0 while count=4.
- Backpressure and simultaneous events: hold out_ready=0 for 5 cycles -> out_inst stable, count stays at 3. Release out_ready with an in_valid packet in the same cycle -> count unchanged and the new packet lands at the tail.
- Flush: with 3 entries, out_valid=1 and in_valid=1 -> next cycle count=0 and out_valid=0, and the incoming packet never issues.

Source files
------------

// File: rtl/reservation_station.sv
// rtl/reservation_station.sv - compacting reservation station with CDB wake-up and oldest-ready issue
module reservation_station #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [115:0]             in_inst,
  input  logic                     cdb_valid,
  input  logic [TAG_W-1:0]         cdb_tag,
  input  logic [31:0]              cdb_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [115:0]             out_inst,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Pending operands carry a producer tag in the low bits of vt; a s2 wake also refreshes memdata.
  function automatic logic [115:0] wake(input logic [115:0] p, input logic v,
                                        input logic [TAG_W-1:0] t, input logic [31:0] d);
    logic [115:0] r;
    r = p;
    if (!p[5] && v && (p[6 +: TAG_W] == t)) begin
      r[37:6] = d;
      r[5]    = 1'b1;
    end
    if (!p[38] && v && (p[39 +: TAG_W] == t)) begin
      r[70:39]  = d;
      r[38]     = 1'b1;
      r[115:84] = d;
    end
    return r;
  endfunction

  logic [115:0]   ent_q [DEPTH];
  logic [115:0]   ent_d [DEPTH];
  logic [CW-1:0]  count_q, count_d, count_s;
  logic           out_valid_q, out_valid_d;
  logic [115:0]   out_inst_q, out_inst_d;
  logic           found, can_sel, issue, accept;
  logic [115:0]   sel_inst;
  logic [DEPTH-1:0] shift;

  assign in_ready = (count_q < DEPTH_C) & ~flush;
  assign accept   = in_valid & in_ready;
  assign can_sel  = ~out_valid_q | out_ready;

  // Oldest ready entry wins; every slot at or above it shifts down when it leaves.
  always_comb begin
    found    = 1'b0;
    sel_inst = '0;
    shift    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!found && (CW'(i) < count_q) && ent_q[i][5] && ent_q[i][38]) begin
        found    = 1'b1;
        sel_inst = ent_q[i];
      end
      shift[i] = found;
    end
  end

  assign issue   = can_sel & found;
  assign count_s = count_q - {{(CW-1){1'b0}}, issue};

  always_comb begin
    out_valid_d = out_valid_q;
    out_inst_d  = out_inst_q;
    count_d     = count_s + {{(CW-1){1'b0}}, accept};
    if (issue) begin
      out_valid_d = 1'b1;
      out_inst_d  = sel_inst;
    end else if (can_sel) begin
      out_valid_d = 1'b0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (issue && shift[i]) begin
        ent_d[i] = (i + 1 < DEPTH) ? wake(ent_q[(i + 1) % DEPTH], cdb_valid, cdb_tag, cdb_data) : '0;
      end else begin
        ent_d[i] = wake(ent_q[i], cdb_valid, cdb_tag, cdb_data);
      end
      // New packet lands at the post-shift tail, with same-cycle CDB capture.
      if (accept && (CW'(i) == count_s)) begin
        ent_d[i] = wake(in_inst, cdb_valid, cdb_tag, cdb_data);
      end
    end
    if (flush) begin
      count_d     = '0;
      out_valid_d = 1'b0;
      out_inst_d  = '0;
      for (int i = 0; i < DEPTH; i++) ent_d[i] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_inst_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_inst_q  <= out_inst_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_inst  = out_inst_q;
  assign count     = count_q;

endmodule

// File: tb/tb_reservation_station.sv
// tb/tb_reservation_station.sv - self-checking bench for reservation_station
module tb_reservation_station;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst_n, flush, in_valid, in_ready, cdb_valid, out_valid, out_ready;
  logic [115:0] in_inst, out_inst;
  logic [4:0]   cdb_tag;
  logic [31:0]  cdb_data;
  logic [2:0]   count;

  always #5 clk = ~clk;

  reservation_station #(.DEPTH(DEPTH), .TAG_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .count(count)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [115:0] exp_q[$];

  typedef struct {
    logic s1v; logic [31:0] v1; logic s2v; logic [31:0] v2; logic [31:0] mem;
    logic acc_cdb; logic [4:0] acc_tag; logic [31:0] acc_data;
    logic late_cdb; logic [4:0] late_tag; logic [31:0] late_data;
    logic [31:0] e1; logic [31:0] e2; logic [31:0] emem;
  } vec_t;

  localparam int NV = 7;
  vec_t tbl [NV];

  function automatic logic [115:0] pk(input logic [4:0] rd, input logic s1v, input logic [31:0] v1,
                                      input logic s2v, input logic [31:0] v2, input logic [12:0] ctrl,
                                      input logic [31:0] mem);
    return {mem, ctrl, v2, s2v, v1, s1v, rd};
  endfunction

  task automatic chk(input string name, input logic [115:0] act, input logic [115:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_i(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [115:0] p);
    in_valid = 1'b1;
    in_inst  = p;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_empty(input int budget);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      tick();
      n++;
    end
    if (exp_q.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: %0d packets outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    tick();
    tick();
  endtask

  // Scoreboard: each accepted output handshake pops the next expected packet.
  always @(negedge clk) begin
    if (rst_n && !flush) begin
      assert (count <= 3'(DEPTH))
      else begin
        n_err++;
        $display("FAIL count_bound: got %0d, limit %0d", count, DEPTH);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_issue: got %h, expected none", out_inst);
        end else begin
          chk("issue", out_inst, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: simulation time exhausted");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    vec_t v;
    logic [115:0] p, pe, p0, p1, p2, p3, p4;
    int n;

    tbl[0] = '{1'b1, 32'h5, 1'b1, 32'h7, 32'h100, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h5, 32'h7, 32'h100};
    tbl[1] = '{1'b0, 32'h3, 1'b1, 32'h7, 32'h200, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'hDEADBEEF, 32'hDEADBEEF, 32'h7, 32'h200};
    tbl[2] = '{1'b1, 32'h44, 1'b0, 32'h9, 32'h300, 1'b1, 5'd9, 32'h11, 1'b0, 5'd0, 32'h0, 32'h44, 32'h11, 32'h11};
    tbl[3] = '{1'b0, 32'h4, 1'b0, 32'h4, 32'h400, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'hCAFE, 32'hCAFE, 32'hCAFE, 32'hCAFE};
    tbl[4] = '{1'b1, 32'h0, 1'b0, 32'h6, 32'h500, 1'b1, 5'd0, 32'h55, 1'b1, 5'd6, 32'h66, 32'h0, 32'h66, 32'h66};
    tbl[5] = '{1'b0, 32'h1, 1'b1, 32'h22, 32'h600, 1'b1, 5'd1, 32'hAA, 1'b0, 5'd0, 32'h0, 32'hAA, 32'h22, 32'h600};
    tbl[6] = '{1'b0, 32'h7, 1'b1, 32'h33, 32'h700, 1'b1, 5'd8, 32'hBB, 1'b1, 5'd7, 32'h77, 32'h77, 32'h33, 32'h700};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_inst = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0; out_ready = 1'b0;
    #12;
    chk_i("reset_count", 32'(count), 32'd0);
    chk_i("reset_out_valid", 32'(out_valid), 32'd0);
    chk_i("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_inst", out_inst, '0);
    tick();
    rst_n = 1'b1;
    tick();

    // Mid-run asynchronous reset with two entries resident and the output register full.
    send(pk(5'd1, 1'b1, 32'h1, 1'b1, 32'h2, 13'h1, 32'h3));
    send(pk(5'd2, 1'b1, 32'h4, 1'b1, 32'h5, 13'h2, 32'h6));
    send(pk(5'd3, 1'b1, 32'h7, 1'b1, 32'h8, 13'h3, 32'h9));
    chk_i("pre_reset_count", 32'(count), 32'd2);
    chk_i("pre_reset_out_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_i("async_reset_count", 32'(count), 32'd0);
    chk_i("async_reset_out_valid", 32'(out_valid), 32'd0);
    chk("async_reset_out_inst", out_inst, '0);
    chk_i("async_reset_in_ready", 32'(in_ready), 32'd1);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Two-cycle in-to-out latency.
    out_ready = 1'b1;
    p = pk(5'd1, 1'b1, 32'd5, 1'b1, 32'd7, 13'h55, 32'h99);
    exp_q.push_back(p);
    send(p);
    chk_i("lat_cycle1_out_valid", 32'(out_valid), 32'd0);
    chk_i("lat_cycle1_count", 32'(count), 32'd1);
    tick();
    chk_i("lat_cycle2_out_valid", 32'(out_valid), 32'd1);
    chk("lat_cycle2_out_inst", out_inst, p);
    wait_empty(10);

    // Single-packet vectors: capture bypass, late wake-up, tag zero, non-matching CDB.
    for (int i = 0; i < NV; i++) begin
      v  = tbl[i];
      p  = pk(5'(i), v.s1v, v.v1, v.s2v, v.v2, 13'(i * 3 + 1), v.mem);
      pe = pk(5'(i), 1'b1, v.e1, 1'b1, v.e2, 13'(i * 3 + 1), v.emem);
      exp_q.push_back(pe);
      in_valid = 1'b1; in_inst = p;
      cdb_valid = v.acc_cdb; cdb_tag = v.acc_tag; cdb_data = v.acc_data;
      tick();
      in_valid = 1'b0; cdb_valid = 1'b0;
      if (v.late_cdb) begin
        repeat (3) tick();
        chk_i("waiting_count", 32'(count), 32'd1);
        chk_i("waiting_out_valid", 32'(out_valid), 32'd0);
        cdb_valid = 1'b1; cdb_tag = v.late_tag; cdb_data = v.late_data;
        tick();
        cdb_valid = 1'b0;
      end
      wait_empty(20);
    end

    // Oldest-first with a blocked head: entries behind it issue around it.
    out_ready = 1'b0;
    p0 = pk(5'd20, 1'b0, 32'd2, 1'b1, 32'h10, 13'd20, 32'hA0);
    p1 = pk(5'd21, 1'b1, 32'h11, 1'b1, 32'h21, 13'd21, 32'hA1);
    p2 = pk(5'd22, 1'b1, 32'h12, 1'b1, 32'h22, 13'd22, 32'hA2);
    p3 = pk(5'd23, 1'b1, 32'h13, 1'b1, 32'h23, 13'd23, 32'hA3);
    p4 = pk(5'd24, 1'b1, 32'h14, 1'b1, 32'h24, 13'd24, 32'hA4);
    exp_q.push_back(p1); exp_q.push_back(p2); exp_q.push_back(p3); exp_q.push_back(p4);
    exp_q.push_back(pk(5'd20, 1'b1, 32'h12345678, 1'b1, 32'h10, 13'd20, 32'hA0));
    send(p0); send(p1); send(p2); send(p3); send(p4);
    chk_i("full_count", 32'(count), 32'd4);
    chk_i("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_out_inst", out_inst, p1);
    out_ready = 1'b1;
    n = 0;
    while (count != 3'd1 && n < 20) begin
      tick();
      n++;
    end
    chk_i("head_left_alone", 32'(count), 32'd1);
    cdb_valid = 1'b1; cdb_tag = 5'd2; cdb_data = 32'h12345678;
    tick();
    cdb_valid = 1'b0;
    wait_empty(20);

    // Backpressure hold, then release with a same-cycle accept.
    out_ready = 1'b0;
    p0 = pk(5'd10, 1'b1, 32'h30, 1'b1, 32'h40, 13'd10, 32'hB0);
    p1 = pk(5'd11, 1'b1, 32'h31, 1'b1, 32'h41, 13'd11, 32'hB1);
    p2 = pk(5'd12, 1'b1, 32'h32, 1'b1, 32'h42, 13'd12, 32'hB2);
    p3 = pk(5'd13, 1'b1, 32'h33, 1'b1, 32'h43, 13'd13, 32'hB3);
    p4 = pk(5'd14, 1'b1, 32'h34, 1'b1, 32'h44, 13'd14, 32'hB4);
    exp_q.push_back(p0); exp_q.push_back(p1); exp_q.push_back(p2);
    exp_q.push_back(p3); exp_q.push_back(p4);
    send(p0); send(p1); send(p2); send(p3);
    chk_i("bp_count", 32'(count), 32'd3);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp_hold_out_inst", out_inst, p0);
      chk_i("bp_hold_count", 32'(count), 32'd3);
    end
    out_ready = 1'b1;
    send(p4);
    chk_i("release_accept_count", 32'(count), 32'd3);
    wait_empty(20);

    // Flush drops resident entries, the output register and the same-cycle input.
    out_ready = 1'b0;
    send(pk(5'd5, 1'b1, 32'h50, 1'b1, 32'h60, 13'd5, 32'hC0));
    send(pk(5'd6, 1'b1, 32'h51, 1'b1, 32'h61, 13'd6, 32'hC1));
    send(pk(5'd7, 1'b1, 32'h52, 1'b1, 32'h62, 13'd7, 32'hC2));
    send(pk(5'd8, 1'b1, 32'h53, 1'b1, 32'h63, 13'd8, 32'hC3));
    chk_i("pre_flush_count", 32'(count), 32'd3);
    flush = 1'b1; in_valid = 1'b1; in_inst = pk(5'd9, 1'b1, 32'h54, 1'b1, 32'h64, 13'd9, 32'hC4);
    #1;
    chk_i("flush_in_ready", 32'(in_ready), 32'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk_i("flush_count", 32'(count), 32'd0);
    chk_i("flush_out_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    repeat (8) tick();
    chk_i("post_flush_count", 32'(count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
